// File: rtl/br_predict_ctrl_pkg.sv
// Shared types for the branch predictor controller: FSM states, 2-bit counters
// and the queued update record, plus the saturating counter helper.
package lc3b_types;

    localparam int BHT_ENTRIES = 64;
    localparam int BHT_IDX_W   = 6;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        STEAL = 2'd2
    } bp_state_t;

    typedef logic [1:0] bp_ctr_t;

    typedef struct packed {
        logic [BHT_IDX_W-1:0] index;
        logic                 taken;
    } bp_update_t;

    // Counters stick at 0 and 3 rather than wrapping
    function automatic bp_ctr_t sat_update(input bp_ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/br_predict_ctrl_if.sv
// Fetch lookup and execute resolution handshake between the pipeline (master)
// and the predictor controller (slave).
interface br_predict_ctrl_if;

    logic       pred_req;
    logic [5:0] pred_index;
    logic       pred_valid;
    logic       pred_taken;
    logic       res_valid;
    logic [5:0] res_index;
    logic       res_taken;
    logic       res_ready;
    logic       busy;

    modport master (
        output pred_req, pred_index, res_valid, res_index, res_taken,
        input  pred_valid, pred_taken, res_ready, busy
    );

    modport slave (
        input  pred_req, pred_index, res_valid, res_index, res_taken,
        output pred_valid, pred_taken, res_ready, busy
    );

endinterface

// File: rtl/br_predict_ctrl_fifo.sv
// Resolution update queue: holds index+taken records until the array port is
// free. Pushes into a full queue are dropped even if a pop happens that cycle.
module bp_update_fifo
    import lc3b_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  bp_update_t push_data,
    input  logic       pop,
    output bp_update_t pop_data,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    bp_update_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/br_predict_ctrl.sv
// Branch history table controller: sweeps the external 64x2 counter array after
// reset, serves fetch lookups at zero latency and drains queued updates.
module br_predict_ctrl
    import lc3b_types::*;
#(
    parameter int      FIFO_DEPTH = 4,
    parameter bp_ctr_t INIT_VAL   = 2'b01,
    parameter int      STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             reset,
    br_predict_ctrl_if.slave bus,
    output logic [5:0]       arr_read_index,
    input  logic [1:0]       arr_dataout,
    output logic             arr_write,
    output logic [5:0]       arr_write_index,
    output logic [1:0]       arr_datain
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    bp_state_t             state;
    logic [BHT_IDX_W-1:0]  sweep_idx;
    logic [STARVE_W-1:0]   starve_cnt;

    bp_update_t            head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  fifo_push;

    logic                  pred_valid;
    logic                  pred_taken;
    logic                  res_ready;
    logic                  busy;

    assign fifo_push      = bus.res_valid && res_ready;
    assign bus.pred_valid = pred_valid;
    assign bus.pred_taken = pred_taken;
    assign bus.res_ready  = res_ready;
    assign bus.busy       = busy;

    bp_update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({bus.res_index, bus.res_taken}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Lookups win the single read port; the head update only runs when fetch
    // is quiet or when starvation forces a STEAL cycle.
    always_comb begin
        pred_valid      = 1'b0;
        pred_taken      = 1'b0;
        res_ready       = 1'b0;
        busy            = 1'b0;
        fifo_pop        = 1'b0;
        arr_read_index  = bus.pred_index;
        arr_write       = 1'b0;
        arr_write_index = sweep_idx;
        arr_datain      = INIT_VAL;
        if (reset) begin
            busy = 1'b1;
        end else begin
            case (state)
                INIT: begin
                    busy      = 1'b1;
                    arr_write = 1'b1;
                end
                IDLE, STEAL: begin
                    res_ready = !fifo_full;
                    if (state == IDLE && bus.pred_req) begin
                        pred_valid = 1'b1;
                        pred_taken = arr_dataout[1];
                    end else if (!fifo_empty) begin
                        arr_read_index  = head.index;
                        arr_write       = 1'b1;
                        arr_write_index = head.index;
                        arr_datain      = sat_update(arr_dataout, head.taken);
                        fifo_pop        = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Starvation counts only cycles where a lookup blocks a pending update
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            sweep_idx  <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    sweep_idx <= sweep_idx + BHT_IDX_W'(1);
                    if (sweep_idx == BHT_IDX_W'(BHT_ENTRIES - 1)) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (bus.pred_req && !fifo_empty) begin
                        if (starve_cnt == STARVE_W'(STARVE_MAX - 1)) begin
                            state      <= STEAL;
                            starve_cnt <= '0;
                        end else begin
                            starve_cnt <= starve_cnt + STARVE_W'(1);
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                STEAL: begin
                    state      <= IDLE;
                    starve_cnt <= '0;
                end
                default: begin
                    state      <= INIT;
                    sweep_idx  <= '0;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_br_predict_ctrl.sv
// Directed bench for br_predict_ctrl with a behavioural 64x2 counter array.
module tb_br_predict_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] arr_read_index;
    logic [1:0] arr_dataout;
    logic       arr_write;
    logic [5:0] arr_write_index;
    logic [1:0] arr_datain;

    logic [1:0] bht [64];
    logic [7:0] wr_q [$];
    logic       log_en;
    int         n_checks;
    int         n_fails;

    br_predict_ctrl_if bus ();

    br_predict_ctrl #(.FIFO_DEPTH(4), .INIT_VAL(2'b01), .STARVE_MAX(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .arr_read_index  (arr_read_index),
        .arr_dataout     (arr_dataout),
        .arr_write       (arr_write),
        .arr_write_index (arr_write_index),
        .arr_datain      (arr_datain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign arr_dataout = bht[arr_read_index];

    always @(posedge clk) begin
        if (arr_write) bht[arr_write_index] <= arr_datain;
    end

    always @(negedge clk) begin
        #1;
        if (log_en && arr_write === 1'b1) wr_q.push_back({arr_write_index, arr_datain});
    end

    task automatic drive_push(input logic [5:0] idx, input logic taken);
        bus.res_valid = 1'b1;
        bus.res_index = idx;
        bus.res_taken = taken;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pred_req = 1'b1;
        bus.pred_index = 6'd3;
        drive_push(6'd1, 1'b1);
        #1;
        n_checks++; if (bus.pred_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_pred_valid: got %b expected 0", bus.pred_valid); end
        n_checks++; if (bus.res_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_res_ready: got %b expected 0", bus.res_ready); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fails++; $display("[TB] FAIL rst_busy: got %b expected 1", bus.busy); end
        n_checks++; if (arr_write !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_arr_write: got %b expected 0", arr_write); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            n_checks++; if (bus.busy !== 1'b1) begin n_fails++; $display("[TB] FAIL sweep_busy[%0d]: got %b expected 1", i, bus.busy); end
            n_checks++; if (arr_write !== 1'b1 || arr_write_index !== 6'(i) || arr_datain !== 2'b01)
                begin n_fails++; $display("[TB] FAIL sweep_write[%0d]: got we=%b idx=%0d data=%b expected we=1 idx=%0d data=01", i, arr_write, arr_write_index, arr_datain, i); end
            n_checks++; if (bus.pred_valid !== 1'b0 || bus.res_ready !== 1'b0)
                begin n_fails++; $display("[TB] FAIL sweep_handshake[%0d]: got pv=%b rr=%b expected 0 0", i, bus.pred_valid, bus.res_ready); end
            @(negedge clk);
        end
        bus.res_valid = 1'b0;
        bus.pred_req = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("[TB] FAIL sweep_done_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.res_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL sweep_done_ready: got %b expected 1", bus.res_ready); end
        n_checks++; if (arr_write !== 1'b0) begin n_fails++; $display("[TB] FAIL sweep_done_idle_write: got %b expected 0", arr_write); end
        @(negedge clk);
    endtask

    task automatic test_taken_saturate();
        logic [7:0] exp_w [3];
        exp_w[0] = {6'd5, 2'b10};
        exp_w[1] = {6'd5, 2'b11};
        exp_w[2] = {6'd5, 2'b11};
        wr_q.delete();
        log_en = 1'b1;
        bus.pred_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_push(6'd5, 1'b1);
            #1;
            n_checks++; if (bus.res_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL sat_res_ready[%0d]: got %b expected 1", i, bus.res_ready); end
            @(negedge clk);
        end
        bus.res_valid = 1'b0;
        repeat (4) @(negedge clk);
        log_en = 1'b0;
        n_checks++; if (wr_q.size() != 3) begin n_fails++; $display("[TB] FAIL sat_write_count: got %0d expected 3", wr_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < wr_q.size()) begin
                n_checks++; if (wr_q[i] !== exp_w[i]) begin n_fails++; $display("[TB] FAIL sat_write[%0d]: got %h expected %h", i, wr_q[i], exp_w[i]); end
            end
        end
        bus.pred_req = 1'b1;
        bus.pred_index = 6'd5;
        #1;
        n_checks++; if (bus.pred_valid !== 1'b1 || bus.pred_taken !== 1'b1)
            begin n_fails++; $display("[TB] FAIL sat_lookup: got pv=%b pt=%b expected 1 1", bus.pred_valid, bus.pred_taken); end
        n_checks++; if (arr_write !== 1'b0) begin n_fails++; $display("[TB] FAIL sat_lookup_write: got %b expected 0", arr_write); end
        @(negedge clk);
        bus.pred_req = 1'b0;
    endtask

    task automatic test_not_taken_floor();
        wr_q.delete();
        log_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_push(6'd0, 1'b0);
            @(negedge clk);
        end
        bus.res_valid = 1'b0;
        repeat (3) @(negedge clk);
        log_en = 1'b0;
        n_checks++; if (wr_q.size() != 2) begin n_fails++; $display("[TB] FAIL floor_write_count: got %0d expected 2", wr_q.size()); end
        for (int i = 0; i < 2; i++) begin
            if (i < wr_q.size()) begin
                n_checks++; if (wr_q[i] !== 8'h00) begin n_fails++; $display("[TB] FAIL floor_write[%0d]: got %h expected 00", i, wr_q[i]); end
            end
        end
        bus.pred_req = 1'b1;
        bus.pred_index = 6'd0;
        #1;
        n_checks++; if (bus.pred_valid !== 1'b1 || bus.pred_taken !== 1'b0)
            begin n_fails++; $display("[TB] FAIL floor_lookup: got pv=%b pt=%b expected 1 0", bus.pred_valid, bus.pred_taken); end
        @(negedge clk);
        bus.pred_req = 1'b0;
    endtask

    task automatic test_starve();
        int   blocked;
        logic steal_seen;
        bus.pred_req = 1'b1;
        bus.pred_index = 6'd7;
        for (int i = 0; i < 4; i++) begin
            drive_push(6'd7, 1'b1);
            #1;
            n_checks++; if (bus.res_ready !== 1'b1 || bus.pred_valid !== 1'b1)
                begin n_fails++; $display("[TB] FAIL starve_fill[%0d]: got rr=%b pv=%b expected 1 1", i, bus.res_ready, bus.pred_valid); end
            @(negedge clk);
        end
        bus.res_valid = 1'b0;
        #1;
        n_checks++; if (bus.res_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL starve_full: got %b expected 0", bus.res_ready); end
        blocked = 3;
        steal_seen = 1'b0;
        for (int c = 0; c < 20 && !steal_seen; c++) begin
            if (bus.pred_valid === 1'b1) begin
                blocked++;
                n_checks++; if (arr_write !== 1'b0) begin n_fails++; $display("[TB] FAIL starve_blocked_write[%0d]: got %b expected 0", c, arr_write); end
                @(negedge clk);
                #1;
            end else begin
                steal_seen = 1'b1;
            end
        end
        n_checks++; if (steal_seen !== 1'b1) begin n_fails++; $display("[TB] FAIL starve_timeout: got no steal cycle expected one within 20"); end
        n_checks++; if (blocked != 8) begin n_fails++; $display("[TB] FAIL starve_blocked_cycles: got %0d expected 8", blocked); end
        n_checks++; if (arr_write !== 1'b1 || arr_write_index !== 6'd7 || arr_datain !== 2'b10)
            begin n_fails++; $display("[TB] FAIL steal_write: got we=%b idx=%0d data=%b expected 1 7 10", arr_write, arr_write_index, arr_datain); end
        n_checks++; if (bus.res_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL steal_ready: got %b expected 0", bus.res_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (bus.pred_valid !== 1'b1 || bus.res_ready !== 1'b1)
            begin n_fails++; $display("[TB] FAIL after_steal: got pv=%b rr=%b expected 1 1", bus.pred_valid, bus.res_ready); end
        drive_push(6'd7, 1'b1);
        @(negedge clk);
        bus.res_valid = 1'b0;
        #1;
        n_checks++; if (bus.res_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL steal_occupancy: got rr=%b expected 0", bus.res_ready); end
        @(negedge clk);
        bus.pred_req = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_push_pop();
        logic [7:0] exp_w [5];
        exp_w[0] = {6'd10, 2'b10};
        exp_w[1] = {6'd11, 2'b00};
        exp_w[2] = {6'd12, 2'b10};
        exp_w[3] = {6'd13, 2'b00};
        exp_w[4] = {6'd14, 2'b10};
        bus.pred_req = 1'b1;
        bus.pred_index = 6'd0;
        drive_push(6'd10, 1'b1);
        @(negedge clk);
        drive_push(6'd11, 1'b0);
        @(negedge clk);
        wr_q.delete();
        log_en = 1'b1;
        bus.pred_req = 1'b0;
        drive_push(6'd12, 1'b1);
        #1;
        n_checks++; if (bus.res_ready !== 1'b1 || arr_write !== 1'b1 || arr_write_index !== 6'd10)
            begin n_fails++; $display("[TB] FAIL pp_same_cycle: got rr=%b we=%b idx=%0d expected 1 1 10", bus.res_ready, arr_write, arr_write_index); end
        @(negedge clk);
        bus.pred_req = 1'b1;
        drive_push(6'd13, 1'b0);
        #1;
        n_checks++; if (bus.res_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL pp_ready_3: got %b expected 1", bus.res_ready); end
        @(negedge clk);
        drive_push(6'd14, 1'b1);
        #1;
        n_checks++; if (bus.res_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL pp_ready_4: got %b expected 1", bus.res_ready); end
        @(negedge clk);
        bus.res_valid = 1'b0;
        #1;
        n_checks++; if (bus.res_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL pp_full: got %b expected 0", bus.res_ready); end
        @(negedge clk);
        bus.pred_req = 1'b0;
        repeat (6) @(negedge clk);
        log_en = 1'b0;
        n_checks++; if (wr_q.size() != 5) begin n_fails++; $display("[TB] FAIL pp_write_count: got %0d expected 5", wr_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < wr_q.size()) begin
                n_checks++; if (wr_q[i] !== exp_w[i]) begin n_fails++; $display("[TB] FAIL pp_order[%0d]: got %h expected %h", i, wr_q[i], exp_w[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_init();
        bus.pred_req = 1'b1;
        bus.pred_index = 6'd0;
        drive_push(6'd20, 1'b1);
        @(negedge clk);
        drive_push(6'd21, 1'b1);
        @(negedge clk);
        bus.res_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.pred_valid !== 1'b0 || bus.res_ready !== 1'b0 || bus.busy !== 1'b1 || arr_write !== 1'b0)
            begin n_fails++; $display("[TB] FAIL reidle_reset_out: got pv=%b rr=%b busy=%b we=%b expected 0 0 1 0", bus.pred_valid, bus.res_ready, bus.busy, arr_write); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            n_checks++; if (arr_write_index !== 6'(i) || bus.busy !== 1'b1)
                begin n_fails++; $display("[TB] FAIL mid_sweep[%0d]: got idx=%0d busy=%b expected %0d 1", i, arr_write_index, bus.busy, i); end
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        n_checks++; if (arr_write !== 1'b0 || bus.busy !== 1'b1)
            begin n_fails++; $display("[TB] FAIL mid_reset_out: got we=%b busy=%b expected 0 1", arr_write, bus.busy); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            n_checks++; if (arr_write !== 1'b1 || arr_write_index !== 6'(i) || bus.busy !== 1'b1)
                begin n_fails++; $display("[TB] FAIL restart_sweep[%0d]: got we=%b idx=%0d busy=%b expected 1 %0d 1", i, arr_write, arr_write_index, bus.busy, i); end
            @(negedge clk);
        end
        bus.pred_req = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("[TB] FAIL restart_done: got busy=%b expected 0", bus.busy); end
        @(negedge clk);
        wr_q.delete();
        log_en = 1'b1;
        repeat (4) @(negedge clk);
        log_en = 1'b0;
        n_checks++; if (wr_q.size() != 0) begin n_fails++; $display("[TB] FAIL flush_queue: got %0d writes expected 0", wr_q.size()); end
    endtask

    initial begin
        n_checks = 0;
        n_fails = 0;
        log_en = 1'b0;
        reset = 1'b1;
        bus.pred_req = 1'b0;
        bus.pred_index = '0;
        bus.res_valid = 1'b0;
        bus.res_index = '0;
        bus.res_taken = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] starting directed tests");
        test_reset();
        test_taken_saturate();
        test_not_taken_floor();
        test_starve();
        test_push_pop();
        test_reset_mid_init();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/br_predict_ctrl.md
BR_PREDICT_CTRL -- requirements
Module: br_predict_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: resolution queue entries (power of 2, >=2).
REQ-002 Parameter INIT_VAL, default 2'b01: counter value written to every entry after reset (weakly not-taken).
REQ-003 Parameter STARVE_MAX, default 8: consecutive blocked cycles before an update steals the port.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pred_req  in  1 / pred_index  in  6  fetch lookup request and BHT index.
REQ-007 pred_valid  out  1 / pred_taken  out  1  lookup served this cycle; predicted direction.
REQ-008 res_valid  in  1 / res_index  in  6 / res_taken  in  1  resolved-branch update from execute.
REQ-009 res_ready  out  1  queue can accept an update this cycle.
REQ-010 busy  out  1  initialisation sweep in progress.
REQ-011 arr_read_index  out  6 / arr_dataout  in  2  read port of the 64x2 counter array (combinational read).
REQ-012 arr_write  out  1 / arr_write_index  out  6 / arr_datain  out  2  write port of the counter array (written at posedge).

Function
REQ-013 FSM states: INIT, IDLE, STEAL; reset enters INIT with sweep index 0.
REQ-014 INIT: arr_write=1, arr_write_index=sweep index, arr_datain=INIT_VAL each cycle; index increments; after index 63 is written, next state IDLE.
REQ-015 busy=1 exactly in INIT (64 cycles after reset deasserts); pred_valid=0 and res_ready=0 in INIT.
REQ-016 IDLE, pred_req=1: arr_read_index=pred_index, pred_valid=1, pred_taken=arr_dataout[1], same cycle (zero latency).
REQ-017 IDLE, pred_req=0, queue non-empty: arr_read_index=head index; arr_write=1 to head index with saturated counter; head popped same cycle.
REQ-018 Saturation: taken -> min(ctr+1, 3); not-taken -> max(ctr-1, 0); 2-bit arithmetic, never wraps.
REQ-019 Starvation counter increments each IDLE cycle with pred_req=1 and queue non-empty; clears otherwise.
REQ-020 Counter reaching STARVE_MAX forces STEAL for one cycle: pred_valid=0, head update performed as in REQ-017, counter cleared, return to IDLE.
REQ-021 res_ready = !full outside INIT; push when res_valid && res_ready; push is not permitted on a full queue even if a pop occurs that cycle.
REQ-022 Simultaneous push and pop: occupancy unchanged, order preserved (FIFO).
REQ-023 A lookup in the same cycle as a write to the same index returns the pre-write value; no bypass.
REQ-024 Two queued updates to the same index are applied in order, each as a separate read-modify-write.
REQ-025 When not writing, arr_write=0; arr_write_index/arr_datain are don't-care.

Reset
REQ-026 reset (any state, including mid-INIT or STEAL) flushes the queue, clears the starvation counter, restarts INIT at index 0.
REQ-027 Output values in reset cycle: pred_valid=0, res_ready=0, busy=1, arr_write=0.

Structure
REQ-028 Package lc3b_types holds the state enum bp_state_t, the 2-bit counter type, and constant BHT_ENTRIES=64.
REQ-029 Queue is sub-module bp_update_fifo (7-bit entries: index + taken; push/pop/full/empty); FSM and saturation logic live in br_predict_ctrl.
REQ-030 Counter array is external; no storage of counters inside this block.

Verification
REQ-031 Reset one cycle -> busy=1 for 64 cycles, writes index 0..63 with 2'b01 in order, busy=0 on cycle 65.
REQ-032 Three res_taken=1 to index 5, pred_req=0 -> writes 2'b10, 2'b11, 2'b11; then pred_req index 5 -> pred_valid=1, pred_taken=1.
REQ-033 Two res_taken=0 to index 0 -> writes 2'b00, 2'b00 (no wrap).
REQ-034 pred_req held 1, push 4 updates -> res_ready=0 at 4 entries; after 8 blocked cycles, one pred_valid=0 cycle with one array write; occupancy drops to 3.
REQ-035 reset asserted at sweep index 30 -> next write is index 0, queue empty, busy=1 for 64 more cycles.
REQ-036 Queue at 2 entries, push and pop same cycle -> occupancy stays 2, next pop returns the older entry.
